// File: rtl/audio_pkg.sv
// Shared types and helpers for the HDMI audio front end: channel mode
// encodings and a saturating arithmetic shift used by the sample datapath.
package audio_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'b00,
    MODE_MONO       = 2'b01,
    MODE_SWAP       = 2'b10,
    MODE_NORMAL_ALT = 2'b11
  } audio_mode_e;

  // Arithmetic right shift, then clamp into a signed field of 'width' bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int shift,
                                                   input int width);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = value >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Audio sample clock generator: divides the pixel clock into a ~50% duty
// clk_audio and a one-cycle sample_stb aligned with each clk_audio rise.
module audio_clk_gen #(
  parameter int DIV_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] audio_div,
  output logic                 clk_audio,
  output logic                 sample_stb
);

  logic [DIV_WIDTH-1:0] count;

  // The >= compare (not ==) means a divisor lowered below the running count
  // wraps on the very next clock instead of counting all the way round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      clk_audio  <= 1'b0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      if (count < audio_div) begin
        count <= count + DIV_WIDTH'(1);
      end else begin
        count      <= '0;
        clk_audio  <= ~clk_audio;
        sample_stb <= ~clk_audio;
      end
    end
  end

endmodule

// File: rtl/hdmi_audio_mixer.sv
// HDMI audio front end: sample clock generation, per-channel pre-scale with
// saturation, mono/swap routing and a click-free ramped volume gain.
module hdmi_audio_mixer
  import audio_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 16,
  parameter int PRE_SHIFT = 2,
  parameter int VOL_BITS  = 4,
  parameter int DIV_WIDTH = 9,
  parameter int RAMP_EN   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_WIDTH-1:0]          audio_div,
  input  logic [CHANNELS*IN_WIDTH-1:0]  audio_in,
  input  logic [VOL_BITS-1:0]           volume,
  input  logic                          mute,
  input  logic [1:0]                    mode,
  output logic                          clk_audio,
  output logic                          sample_stb,
  output logic [CHANNELS*OUT_WIDTH-1:0] audio_out,
  output logic                          out_valid,
  output logic [VOL_BITS:0]             gain
);

  localparam int LOG2C = $clog2(CHANNELS);
  localparam int GW    = VOL_BITS + 1;
  localparam int PW    = OUT_WIDTH + VOL_BITS + 2;

  audio_clk_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .audio_div (audio_div),
    .clk_audio (clk_audio),
    .sample_stb(sample_stb)
  );

  // Gain target: all-ones volume maps to 2^VOL_BITS so unity is exact.
  logic [GW-1:0] target_gain;

  always_comb begin
    target_gain = GW'(volume);
    if (mute || (volume == '0)) begin
      target_gain = '0;
    end else if (&volume) begin
      target_gain = GW'(1) << VOL_BITS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain <= '0;
    end else if (sample_stb) begin
      if (RAMP_EN == 0) begin
        gain <= target_gain;
      end else if (gain < target_gain) begin
        gain <= gain + GW'(1);
      end else if (gain > target_gain) begin
        gain <= gain - GW'(1);
      end
    end
  end

  // Three-stage pipeline: capture (S1), scale/route (S2), gain (S3).
  // out_valid is a one-cycle strobe without back-pressure; audio_out is
  // updated in that cycle and then held until the next strobe.
  logic [CHANNELS*IN_WIDTH-1:0]           s1_q;
  audio_mode_e                            mode_q;
  logic                                   v1_q;
  logic                                   v2_q;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]     s2_d;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]     s2_q;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]     scaled;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]     norm_sat;
  logic signed [63:0]                     ext [CHANNELS];
  logic signed [PW-1:0]                   prod [CHANNELS];
  logic signed [63:0]                     mono_sum;
  logic [OUT_WIDTH-1:0]                   mono_sat;

  // Mono sums the shifted but not yet saturated values, so one loud channel
  // cannot clip before averaging.
  always_comb begin
    mono_sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mono_sum = mono_sum + (ext[k] >>> PRE_SHIFT);
    end
  end

  assign mono_sat = OUT_WIDTH'(sat_shift(mono_sum, LOG2C, OUT_WIDTH));

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ext[k]      = 64'($signed(s1_q[k*IN_WIDTH +: IN_WIDTH]));
    assign norm_sat[k] = OUT_WIDTH'(sat_shift(ext[k], PRE_SHIFT, OUT_WIDTH));

    assign s2_d[k] = (mode_q == MODE_MONO) ? mono_sat :
                     (mode_q == MODE_SWAP) ? norm_sat[CHANNELS-1-k] :
                                             norm_sat[k];

    // Gain is unsigned; the extra zero bit keeps the multiply signed.
    assign prod[k]   = PW'($signed(s2_q[k])) * PW'($signed({1'b0, gain}));
    assign scaled[k] = OUT_WIDTH'(prod[k] >>> VOL_BITS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      mode_q    <= MODE_NORMAL;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s2_q      <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      v1_q      <= sample_stb;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (sample_stb) begin
        s1_q   <= audio_in;
        mode_q <= audio_mode_e'(mode);
      end
      if (v1_q) begin
        s2_q <= s2_d;
      end
      if (v2_q) begin
        audio_out <= scaled;
      end
    end
  end

endmodule
